// File: rtl/spio_hss_multiplexer_reg_access_master_pkg.sv
// Shared definitions for the multiplexer register access master: FSM states,
// default widths and the register address map used by the bank and the bench.
package spio_hss_multiplexer_reg_access_master_pkg;

    localparam int REGA_BITS        = 8;
    localparam int REGD_BITS        = 32;
    localparam int LEN_BITS_DEFAULT = 4;

    // Response beat layout: address, data and last flag.
    localparam int RSP_BEAT_BITS = REGA_BITS + REGD_BITS + 1;

    localparam logic [REGA_BITS-1:0] VERS_REG = 8'h00;
    localparam logic [REGA_BITS-1:0] IDSO_REG = 8'h01;
    localparam logic [REGA_BITS-1:0] CRCE_REG = 8'h10;

    localparam logic [REGD_BITS-1:0] VERSION = 32'h0001_0203;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RSP
    } state_t;

endpackage

// File: rtl/spio_hss_multiplexer_reg_access_master.sv
// Register access initiator: turns host write / burst-read commands into
// register bank cycles and returns one response beat per register read.
module spio_hss_multiplexer_reg_access_master
    import spio_hss_multiplexer_reg_access_master_pkg::*;
#(
    parameter int ADDR_BITS = REGA_BITS,
    parameter int DATA_BITS = REGD_BITS,
    parameter int LEN_BITS  = LEN_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_vld,
    output logic                 cmd_rdy,
    input  logic                 cmd_wr,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [DATA_BITS-1:0] cmd_data,
    input  logic [LEN_BITS-1:0]  cmd_len,
    output logic                 rsp_vld,
    input  logic                 rsp_rdy,
    output logic [ADDR_BITS-1:0] rsp_addr,
    output logic [DATA_BITS-1:0] rsp_data,
    output logic                 rsp_last,
    output logic                 busy,
    output logic                 reg_write,
    output logic [ADDR_BITS-1:0] reg_addr,
    output logic [DATA_BITS-1:0] reg_write_data,
    input  logic [DATA_BITS-1:0] reg_read_data
);

    state_t               state;
    logic [ADDR_BITS-1:0] cur_addr;
    logic [LEN_BITS-1:0]  remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cur_addr       <= '0;
            remaining      <= '0;
            cmd_rdy        <= 1'b0;
            rsp_vld        <= 1'b0;
            rsp_addr       <= '0;
            rsp_data       <= '0;
            rsp_last       <= 1'b0;
            busy           <= 1'b0;
            reg_write      <= 1'b0;
            reg_addr       <= '0;
            reg_write_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_rdy <= 1'b1;
                    if (cmd_vld && cmd_rdy) begin
                        cmd_rdy  <= 1'b0;
                        busy     <= 1'b1;
                        cur_addr <= cmd_addr;
                        reg_addr <= cmd_addr;
                        if (cmd_wr) begin
                            reg_write      <= 1'b1;
                            reg_write_data <= cmd_data;
                            state          <= ST_WR;
                        end else begin
                            remaining <= cmd_len;
                            state     <= ST_RD_ISSUE;
                        end
                    end
                end

                ST_WR: begin
                    reg_write <= 1'b0;
                    busy      <= 1'b0;
                    cmd_rdy   <= 1'b1;
                    state     <= ST_IDLE;
                end

                // reg_addr was loaded on entry; the bank registers it this cycle.
                ST_RD_ISSUE: begin
                    state <= ST_RD_WAIT;
                end

                ST_RD_WAIT: begin
                    rsp_vld  <= 1'b1;
                    rsp_addr <= cur_addr;
                    rsp_data <= reg_read_data;
                    rsp_last <= (remaining == '0);
                    state    <= ST_RSP;
                end

                ST_RSP: begin
                    if (rsp_rdy) begin
                        rsp_vld <= 1'b0;
                        if (rsp_last) begin
                            busy    <= 1'b0;
                            cmd_rdy <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            // Address wraps naturally at the top of the map.
                            cur_addr  <= cur_addr + ADDR_BITS'(1);
                            reg_addr  <= cur_addr + ADDR_BITS'(1);
                            remaining <= remaining - LEN_BITS'(1);
                            state     <= ST_RD_ISSUE;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
